// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//
// Shares the single register-file write port between two writeback requesters:
//   A - pipeline writeback stage
//   B - late-completion source (multi-cycle results, memory fills)
// On conflict the grant alternates round-robin. The winning write is registered for exactly
// one cycle and then drives the register-file write port. A one-hot mask of the register
// being written is exported for hazard/bypass logic.
//
// Ports:
//   clk                         clock, all state updates on the rising edge
//   rst                         synchronous active-high reset
//   flush                       squashes every acceptance in the current cycle
//   a_valid/a_ready/a_reg/a_data  requester A handshake and write payload
//   b_valid/b_ready/b_reg/b_data  requester B handshake and write payload
//   WriteReg/DstReg/DstData     registered register-file write enable, ID and data
//   wr_mask                     one-hot of DstReg while WriteReg is high, else zero

module regfile_wr_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_reg,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_reg,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 WriteReg,
  output logic [ADDR_W-1:0]    DstReg,
  output logic [DATA_W-1:0]    DstData,
  output logic [2**ADDR_W-1:0] wr_mask
);

  typedef enum logic {
    PtrA = 1'b0,
    PtrB = 1'b1
  } ptr_e;

  ptr_e              r_ptr;
  ptr_e              w_ptr_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_dst;
  logic [DATA_W-1:0] r_data;

  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_a_acc;
  logic              w_b_acc;
  logic              w_acc;
  logic [ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;

  // Ready ignores the requester's own valid; when both are valid only the requester holding
  // priority sees ready, so at most one acceptance can happen per cycle.
  always_comb begin
    w_a_ready  = ~flush & (~b_valid | (r_ptr == PtrA));
    w_b_ready  = ~flush & (~a_valid | (r_ptr == PtrB));
    w_a_acc    = a_valid & w_a_ready;
    w_b_acc    = b_valid & w_b_ready;
    w_acc      = w_a_acc | w_b_acc;
    w_sel_reg  = w_a_acc ? a_reg  : b_reg;
    w_sel_data = w_a_acc ? a_data : b_data;
  end

  // Priority only moves on a contested grant; a lone requester never disturbs it.
  always_comb begin
    w_ptr_d = r_ptr;
    if (a_valid & b_valid & w_acc) begin
      w_ptr_d = w_a_acc ? PtrB : PtrA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_dst  <= '0;
      r_data <= '0;
      r_ptr  <= PtrA;
    end else begin
      // Register 0 is hardwired zero: the handshake completes but no write is issued.
      r_we <= w_acc & (w_sel_reg != '0);
      if (w_acc) begin
        r_dst  <= w_sel_reg;
        r_data <= w_sel_data;
      end
      r_ptr <= w_ptr_d;
    end
  end

  // Decoded from the registered state so it always agrees with WriteReg/DstReg.
  always_comb begin
    wr_mask = '0;
    if (r_we) begin
      wr_mask[r_dst] = 1'b1;
    end
  end

  assign a_ready  = w_a_ready;
  assign b_ready  = w_b_ready;
  assign WriteReg = r_we;
  assign DstReg   = r_dst;
  assign DstData  = r_data;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] wr_mask;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wr_arbiter #(
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_reg   (a_reg),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_reg   (b_reg),
    .b_data  (b_data),
    .WriteReg(WriteReg),
    .DstReg  (DstReg),
    .DstData (DstData),
    .wr_mask (wr_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Who wins this cycle: 0 = nobody, 1 = A, 2 = B.
  function automatic int winner(input logic fl, input logic av, input logic bv,
                                input bit b_has_prio);
    if (fl) return 0;
    if (av && bv) return b_has_prio ? 2 : 1;
    if (av) return 1;
    if (bv) return 2;
    return 0;
  endfunction

  bit        m_b_prio = 1'b0;
  bit        m_we     = 1'b0;
  bit [3:0]  m_reg    = '0;
  bit [15:0] m_data   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_b_prio <= 1'b0;
      m_we     <= 1'b0;
      m_reg    <= '0;
      m_data   <= '0;
    end else begin
      case (winner(flush, a_valid, b_valid, m_b_prio))
        1: begin
          m_we   <= (a_reg != 0);
          m_reg  <= a_reg;
          m_data <= a_data;
          if (b_valid) m_b_prio <= 1'b1;
        end
        2: begin
          m_we   <= (b_reg != 0);
          m_reg  <= b_reg;
          m_data <= b_data;
          if (a_valid) m_b_prio <= 1'b0;
        end
        default: m_we <= 1'b0;
      endcase
    end
  end

  // Compare every cycle on the falling edge, away from input changes and the active edge.
  always @(negedge clk) begin
    chk("m_a_ready", {31'd0, a_ready},
        {31'd0, !flush && (!b_valid || !m_b_prio)});
    chk("m_b_ready", {31'd0, b_ready},
        {31'd0, !flush && (!a_valid || m_b_prio)});
    chk("m_WriteReg", {31'd0, WriteReg}, {31'd0, m_we});
    chk("m_DstReg", {28'd0, DstReg}, {28'd0, m_reg});
    chk("m_DstData", {16'd0, DstData}, {16'd0, m_data});
    chk("m_wr_mask", {16'd0, wr_mask}, m_we ? (32'd1 << m_reg) : 32'd0);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    step(); step();
    chk("rst_WriteReg", {31'd0, WriteReg}, 32'd0);
    chk("rst_DstReg", {28'd0, DstReg}, 32'd0);
    chk("rst_DstData", {16'd0, DstData}, 32'd0);
    chk("rst_wr_mask", {16'd0, wr_mask}, 32'd0);
    rst = 1'b0;

    // 1: A alone
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1234;
    #1 chk("t1_a_ready", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0;
    chk("t1_WriteReg", {31'd0, WriteReg}, 32'd1);
    chk("t1_DstReg", {28'd0, DstReg}, 32'd3);
    chk("t1_DstData", {16'd0, DstData}, 32'h1234);
    chk("t1_wr_mask", {16'd0, wr_mask}, 32'h0008);
    step();
    chk("t1_idle_WriteReg", {31'd0, WriteReg}, 32'd0);

    // 2: conflict; A keeps presenting a new write so B's grant moves priority back to A
    a_valid = 1'b1; a_reg = 4'd5; a_data = 16'hAAAA;
    b_valid = 1'b1; b_reg = 4'd9; b_data = 16'h5555;
    #1 chk("t2_c0_a_ready", {31'd0, a_ready}, 32'd1);
    chk("t2_c0_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    a_reg = 4'd6; a_data = 16'h6666;
    chk("t2_c1_b_ready", {31'd0, b_ready}, 32'd1);
    chk("t2_c1_a_ready", {31'd0, a_ready}, 32'd0);
    chk("t2_c1_DstReg", {28'd0, DstReg}, 32'd5);
    step();
    b_valid = 1'b0;
    chk("t2_c2_DstReg", {28'd0, DstReg}, 32'd9);
    chk("t2_c2_DstData", {16'd0, DstData}, 32'h5555);
    chk("t2_c2_a_ready", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0;
    chk("t2_c3_DstReg", {28'd0, DstReg}, 32'd6);

    // 3: sustained contention, grants must alternate A,B,A,B,A,B
    a_valid = 1'b1; a_reg = 4'd1; a_data = 16'h0A00;
    b_valid = 1'b1; b_reg = 4'd8; b_data = 16'h0B00;
    for (int i = 0; i < 6; i++) begin
      #1 chk("t3_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("t3_WriteReg", {31'd0, WriteReg}, 32'd1);
      step();
      if (i % 2 == 0) begin
        a_reg = a_reg + 4'd1; a_data = a_data + 16'd1;
      end else begin
        b_reg = b_reg + 4'd1; b_data = b_data + 16'd1;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_last_DstReg", {28'd0, DstReg}, 32'd10);
    chk("t3_last_DstData", {16'd0, DstData}, 32'h0B02);
    step();

    // 4: write to R0 is consumed but not performed
    b_valid = 1'b1; b_reg = 4'd0; b_data = 16'hFFFF;
    #1 chk("t4_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    chk("t4_WriteReg", {31'd0, WriteReg}, 32'd0);
    chk("t4_wr_mask", {16'd0, wr_mask}, 32'd0);
    chk("t4_DstData", {16'd0, DstData}, 32'hFFFF);

    // 5: flush blocks both, priority unchanged
    a_valid = 1'b1; a_reg = 4'd2; a_data = 16'h2222;
    b_valid = 1'b1; b_reg = 4'd4; b_data = 16'h4444;
    flush = 1'b1;
    #1 chk("t5_a_ready", {31'd0, a_ready}, 32'd0);
    chk("t5_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    flush = 1'b0;
    #1 chk("t5_WriteReg", {31'd0, WriteReg}, 32'd0);
    chk("t5_a_wins", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t5_DstReg", {28'd0, DstReg}, 32'd2);

    // 6: reset mid-stream drops the write and returns priority to A
    a_valid = 1'b1; a_reg = 4'd7; a_data = 16'h7777;
    step();
    a_valid = 1'b0; rst = 1'b1;
    chk("t6_pre_WriteReg", {31'd0, WriteReg}, 32'd1);
    chk("t6_pre_DstReg", {28'd0, DstReg}, 32'd7);
    step();
    rst = 1'b0;
    chk("t6_WriteReg", {31'd0, WriteReg}, 32'd0);
    chk("t6_DstReg", {28'd0, DstReg}, 32'd0);
    chk("t6_DstData", {16'd0, DstData}, 32'd0);
    chk("t6_wr_mask", {16'd0, wr_mask}, 32'd0);
    a_valid = 1'b1; b_valid = 1'b1;
    #1 chk("t6_ptr_a", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
